// File: rtl/gb_ext_bridge.sv
// Host-bus bridge to NCH external sub-bus windows: registered per-channel
// address/write-data, fixed-latency read return, busy interlock, sticky error.

module gb_ext_ch #(
    parameter int SUB_AW = 8,
    parameter int DW     = 32
) (
    input  logic              gb_clk,
    input  logic              gb_rst_n,
    input  logic              ld_addr,
    input  logic              ld_data,
    input  logic [SUB_AW-1:0] sub,
    input  logic [DW-1:0]     wdata,
    output logic [SUB_AW-1:0] ext_addr,
    output logic [DW-1:0]     ext_wdata,
    output logic              ext_we
);
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            ext_addr  <= '0;
            ext_wdata <= '0;
            ext_we    <= 1'b0;
        end else begin
            ext_we <= ld_data;
            if (ld_addr) ext_addr  <= sub;
            if (ld_data) ext_wdata <= wdata;
        end
    end
endmodule

module gb_ext_bridge #(
    parameter int          AW        = 12,
    parameter int          DW        = 32,
    parameter int          NCH       = 4,
    parameter int          SUB_AW    = 8,
    parameter int          BASE      = 0,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] MISS_DATA = 32'hDEADBEEF
) (
    input  logic                  gb_clk,
    input  logic                  gb_rst_n,
    input  logic [AW-1:0]         gb_addr,
    input  logic [DW-1:0]         gb_dout,
    input  logic                  gb_we,
    input  logic                  gb_re,
    output logic [DW-1:0]         gb_din,
    output logic                  gb_rvalid,
    output logic                  gb_busy,
    output logic                  gb_err,
    input  logic                  gb_err_clr,
    output logic [NCH*SUB_AW-1:0] ext_addr,
    output logic [NCH*DW-1:0]     ext_wdata,
    output logic [NCH-1:0]        ext_we,
    input  logic [NCH*DW-1:0]     ext_rdata
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] MISS_W = DW'(MISS_DATA);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                 state;
    logic [2:0]             cnt;
    logic [CW-1:0]          rd_ch;
    logic                   rd_miss;

    logic                   borrow;
    logic [AW-1:0]          off;
    logic [AW-SUB_AW-1:0]   win;
    logic [CW-1:0]          ch;
    logic [SUB_AW-1:0]      sub;
    logic                   hit;
    logic                   accept;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   proto_err;
    logic [NCH-1:0]         sel;
    logic [NCH-1:0][DW-1:0] rdata_v;

    // Borrow out of the subtraction doubles as the "below BASE" test.
    assign {borrow, off} = {1'b0, gb_addr} - {1'b0, AW'(BASE)};
    assign win     = off[AW-1:SUB_AW];
    assign sub     = off[SUB_AW-1:0];
    assign ch      = CW'(win);
    assign hit     = !borrow && (32'(win) < NCH);
    assign rdata_v = ext_rdata;

    // The completing edge of a read behaves like IDLE, so reads can chain
    // with no bubble.
    assign accept    = (state == IDLE) || (cnt == 3'd0);
    assign wr_acc    = accept && gb_we;
    assign rd_acc    = accept && gb_re && !gb_we;
    assign proto_err = ((gb_we || gb_re) && !accept) || (accept && gb_we && gb_re);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++)
            sel[i] = hit && (ch == CW'(i));
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gb_ext_ch #(.SUB_AW(SUB_AW), .DW(DW)) u_ch (
            .gb_clk    (gb_clk),
            .gb_rst_n  (gb_rst_n),
            .ld_addr   (sel[i] && (wr_acc || rd_acc)),
            .ld_data   (sel[i] && wr_acc),
            .sub       (sub),
            .wdata     (gb_dout),
            .ext_addr  (ext_addr[i*SUB_AW +: SUB_AW]),
            .ext_wdata (ext_wdata[i*DW +: DW]),
            .ext_we    (ext_we[i])
        );
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            rd_ch     <= '0;
            rd_miss   <= 1'b0;
            gb_din    <= '0;
            gb_rvalid <= 1'b0;
            gb_busy   <= 1'b0;
            gb_err    <= 1'b0;
        end else begin
            gb_rvalid <= 1'b0;
            if (proto_err)
                gb_err <= 1'b1;
            else if (gb_err_clr)
                gb_err <= 1'b0;

            if (state == RD_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end else begin
                if (state == RD_WAIT) begin
                    gb_din    <= rd_miss ? MISS_W : rdata_v[rd_ch];
                    gb_rvalid <= 1'b1;
                end
                if (rd_acc) begin
                    state   <= RD_WAIT;
                    cnt     <= 3'(RD_LAT);
                    rd_ch   <= ch;
                    rd_miss <= !hit;
                    gb_busy <= 1'b1;
                end else begin
                    state   <= IDLE;
                    gb_busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/gb_ext_bridge.md
Name: gb_ext_bridge

Overview:
Parametrised bridge from the host bus to NCH external sub-buses, each with a 2^SUB_AW-word window and a fixed external read latency. It is the successor to single, hand-wired external-bus hookups. It adds an explicit read strobe with a read-data-valid return, a busy interlock, a miss pattern for unmapped addresses, and a sticky protocol-error flag. It sits between the host decode and external instances, one bridge per module that owns external devices.

Parameters:
AW, 12, host address width
DW, 32, data width (host and all channels)
NCH, 4, number of external channels (1..16)
SUB_AW, 8, address width per channel window; requires BASE + NCH*2^SUB_AW <= 2^AW
BASE, 0, host word address of channel 0 window
RD_LAT, 1, external read latency in cycles (0..7); 0 = combinational rdata
MISS_DATA, 32'hDEADBEEF, read data returned for unmapped addresses (truncated to DW)

Ports:
gb_clk  input  1  bus clock, all logic on rising edge
gb_rst_n  input  1  asynchronous active-low reset
gb_addr  input  AW  host word address
gb_dout  input  DW  host write data
gb_we  input  1  write strobe, single cycle
gb_re  input  1  read strobe, single cycle
gb_din  output  DW  read data to host
gb_rvalid  output  1  one-cycle pulse, gb_din valid
gb_busy  output  1  read outstanding
gb_err  output  1  sticky protocol error
gb_err_clr  input  1  clears gb_err
ext_addr  output  NCH*SUB_AW  per-channel address, channel i at [i*SUB_AW +: SUB_AW]
ext_wdata  output  NCH*DW  per-channel write data
ext_we  output  NCH  per-channel write enable
ext_rdata  input  NCH*DW  per-channel read data

Behaviour:
- Clock gb_clk, reset gb_rst_n asynchronous active-low (one clock; no other clock domains).
- Reset values: gb_din=0, gb_rvalid=0, gb_busy=0, gb_err=0, ext_addr=0, ext_wdata=0, ext_we=0, state=IDLE, wait counter=0.
- Decode: off = gb_addr - BASE; hit when gb_addr >= BASE and (off >> SUB_AW) < NCH; ch = off >> SUB_AW; sub = off[SUB_AW-1:0].
- ext_addr and ext_wdata are registered. A channel's fields change only on an accepted access to that channel; otherwise they hold.
- FSM states: IDLE, RD_WAIT.
- IDLE, gb_we=1:
  - Hit: at edge E0, register ext_addr[ch]=sub and ext_wdata[ch]=gb_dout, and assert ext_we[ch] for exactly the cycle after E0.
  - Miss: write dropped silently; no error.
  - Remain in IDLE; a write can be accepted every cycle.
- IDLE, gb_re=1 (gb_we=0), at E0:
  - Hit: register ext_addr[ch]=sub, latch ch, load counter=RD_LAT, go to RD_WAIT, assert gb_busy.
  - Miss: same timing, flagged miss, no ext_addr change.
- RD_WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0, i.e. E(1+RD_LAT), capture gb_din = ext_rdata[ch] (or MISS_DATA on a miss).
  - At that same edge pulse gb_rvalid for one cycle, deassert gb_busy, return to IDLE.
  - Read latency from strobe edge to gb_rvalid visible is RD_LAT+1 cycles.
- A new gb_re is accepted on the same edge that gb_busy falls, i.e. back-to-back at a period of RD_LAT+1.
- gb_din holds its last value between reads.
- Protocol errors set gb_err:
  - gb_we or gb_re while in RD_WAIT: strobe dropped, err set.
  - gb_we and gb_re on the same cycle in IDLE: write performed, read dropped, err set.
- gb_err clears on gb_err_clr. If gb_err_clr and a new error occur on the same edge, set wins.
- Reset asserted mid-read: immediately IDLE, all outputs return to reset values, no gb_rvalid ever issued for that read.
- ext_we is never asserted on more than one channel in any cycle.

Test Plan:
- Defaults (NCH=4, SUB_AW=8, BASE=0, RD_LAT=1), write addr 0x1A5 data 0x12345678 -> ext_addr[1]=0xA5, ext_wdata[1]=0x12345678, ext_we=4'b0010 for one cycle; other channels unchanged.
- Read addr 0x305, ext_rdata[3] model returns 0xCAFE0305 one cycle after address -> gb_rvalid pulses 2 cycles after gb_re edge with gb_din=0xCAFE0305; gb_busy high for that interval.
- Read addr 0x400 (unmapped) -> gb_rvalid after 2 cycles, gb_din=0xDEADBEEF, no ext_we, ext_addr unchanged.
- gb_re at 0x010, then gb_we on the next cycle -> write dropped (ext_we stays 0), gb_err=1, read completes normally; gb_err_clr -> gb_err=0.
- RD_LAT=0 and RD_LAT=7 builds: back-to-back reads issued as soon as gb_busy falls -> rvalid period 1 and 8 cycles respectively, data correct per read.
- Reset pulsed 1 cycle after gb_re -> no gb_rvalid, gb_busy=0, gb_din=0, gb_err=0; next read completes normally.
